// File: rtl/nextkms_pkg.sv
// Shared opcodes, reset-frame pattern, FSM encoding and sample layout for the
// NeXT KMS frame decoder.
package nextkms_pkg;

  localparam logic [7:0]  OP_AUDIO    = 8'hC7;
  localparam logic [7:0]  OP_VOL      = 8'hC4;
  localparam logic [7:0]  OP_BRIGHT   = 8'hC5;
  localparam logic [7:0]  OP_POLL     = 8'hC6;
  localparam logic [39:0] RESET_FRAME = 40'hFF_FFFF_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } sample_t;

endpackage

// File: rtl/nextkms_sample_fifo.sv
// First-word fall-through stereo sample FIFO. Pointers carry one extra MSB so
// full and empty are told apart without a separate count. A push into a full
// FIFO is taken only when a pop frees the head slot in the same cycle.
module nextkms_sample_fifo
  import nextkms_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  input  logic        flush,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  sample_t     mem [DEPTH];
  logic [AW:0] wp, rp;
  logic        wr_en, rd_en;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  // Head is forced to zero while empty so nothing stale leaks out after reset.
  assign dout  = empty ? 32'h0 : mem[rp[AW-1:0]];

  // Pointer update; flush collapses both pointers and overrides push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en) wp <= wp + PTR_ONE;
      if (rd_en) rp <= rp + PTR_ONE;
    end
  end

  // Storage write; when full the slot written is the head being popped.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/nextkms_frame_decoder.sv
// NeXT KMS frame decoder: edge-detects the receiver strobe, latches the frame,
// executes its opcode one cycle later and buffers audio samples in a FWFT FIFO.
// Optional reset-frame handling is enabled with `define NEXTKMS_RESET_FRAME_EN.
module nextkms_frame_decoder
  import nextkms_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [39:0]      frame_data,
  input  logic             frame_valid,
  output logic [15:0]      smp_left,
  output logic [15:0]      smp_right,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic [5:0]       volume,
  output logic [5:0]       brightness,
  output logic             kbd_poll,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] ovr_cnt,
  output logic             kms_reset
);

  state_t      state_q, state_d;
  logic        fv_q;
  logic [39:0] frm_q;
  logic        frm_edge;
  logic [7:0]  opcode;
  logic        do_audio, do_vol, do_bright, do_poll, do_unknown, do_rst;
  logic        fifo_full, fifo_empty, fifo_pop, fifo_push, drop;
  logic [31:0] fifo_dout;

  assign frm_edge = frame_valid && !fv_q;
  assign opcode   = frm_q[39:32];

  // Strobe history, frame capture on the rising edge, and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q    <= 1'b0;
      frm_q   <= '0;
      state_q <= IDLE;
    end else begin
      fv_q    <= frame_valid;
      state_q <= state_d;
      if (frm_edge) frm_q <= frame_data;
    end
  end

  // Next state and opcode decode; an edge arriving in EXEC queues another EXEC.
  always_comb begin
    state_d    = frm_edge ? EXEC : IDLE;
    do_audio   = 1'b0;
    do_vol     = 1'b0;
    do_bright  = 1'b0;
    do_poll    = 1'b0;
    do_unknown = 1'b0;
    do_rst     = 1'b0;
`ifdef NEXTKMS_RESET_FRAME_EN
    do_rst     = (state_q == EXEC) && (frm_q == RESET_FRAME);
`endif
    if (state_q == EXEC && !do_rst) begin
      case (opcode)
        OP_AUDIO:  do_audio   = 1'b1;
        OP_VOL:    do_vol     = 1'b1;
        OP_BRIGHT: do_bright  = 1'b1;
        OP_POLL:   do_poll    = 1'b1;
        default:   do_unknown = 1'b1;
      endcase
    end
  end

  assign fifo_pop  = smp_ready && !fifo_empty;
  assign fifo_push = do_audio && (!fifo_full || fifo_pop);
  assign drop      = do_audio && fifo_full && !fifo_pop;

  // Control registers, poll pulse and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      volume     <= '0;
      brightness <= '0;
      kbd_poll   <= 1'b0;
      err_cnt    <= '0;
      ovr_cnt    <= '0;
    end else begin
      kbd_poll <= do_poll;
      if (do_rst) begin
        volume     <= '0;
        brightness <= '0;
        err_cnt    <= '0;
        ovr_cnt    <= '0;
      end else begin
        if (do_vol)    volume     <= frm_q[5:0];
        if (do_bright) brightness <= frm_q[5:0];
        if (do_unknown && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        if (drop && ovr_cnt != '1)       ovr_cnt <= ovr_cnt + CNT_W'(1);
      end
    end
  end

`ifdef NEXTKMS_RESET_FRAME_EN
  logic kms_reset_q;

  // One-cycle pulse following a reset frame's EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) kms_reset_q <= 1'b0;
    else        kms_reset_q <= do_rst;
  end

  assign kms_reset = kms_reset_q;
`else
  assign kms_reset = 1'b0;
`endif

  nextkms_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (frm_q[31:0]),
    .pop   (fifo_pop),
    .flush (do_rst),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign smp_valid = !fifo_empty;
  assign smp_left  = fifo_dout[31:16];
  assign smp_right = fifo_dout[15:0];

endmodule

// File: tb/tb_nextkms_frame_decoder.sv
// Self-checking bench for nextkms_frame_decoder with a sample scoreboard queue.
module tb_nextkms_frame_decoder;

  localparam int DEPTH = 8;
  localparam int GAP   = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] frame_data = '0;
  logic        frame_valid = 1'b0;
  logic        smp_ready = 1'b0;
  logic [15:0] smp_left, smp_right;
  logic        smp_valid;
  logic [5:0]  volume, brightness;
  logic        kbd_poll;
  logic [7:0]  err_cnt, ovr_cnt;
  logic        kms_reset;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int exp_err = 0;
  int exp_ovr = 0;
  int poll_seen = 0;
  int kms_seen = 0;

  nextkms_frame_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_data(frame_data), .frame_valid(frame_valid),
    .smp_left(smp_left), .smp_right(smp_right), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .volume(volume), .brightness(brightness),
    .kbd_poll(kbd_poll), .err_cnt(err_cnt), .ovr_cnt(ovr_cnt), .kms_reset(kms_reset)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kbd_poll)  poll_seen++;
    if (kms_reset) kms_seen++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; the edge is accepted at the first posedge, EXEC is the
  // following cycle, results are visible on return when hold <= 2.
  task automatic send_frame(input logic [39:0] d, input int hold, input bit pop_exec);
    @(posedge clk); #1;
    frame_data  = d;
    frame_valid = 1'b1;
    @(posedge clk); #1;
    if (pop_exec) begin
      checks++;
      if (smp_valid !== 1'b1 || exp_q.size() == 0 || {smp_left, smp_right} !== exp_q[0]) begin
        errors++;
        $display("FAIL pop_in_exec: got v=%b %h, want v=1 %h", smp_valid, {smp_left, smp_right},
                 exp_q.size() ? exp_q[0] : 32'h0);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      smp_ready = 1'b1;
    end
    if (hold <= 1) frame_valid = 1'b0;
    @(posedge clk); #1;
    smp_ready = 1'b0;
    for (int i = 2; i < hold; i++) begin
      @(posedge clk); #1;
    end
    frame_valid = 1'b0;
  endtask

  task automatic send_audio(input logic [31:0] s, input bit pop_exec);
    bit dropped;
    dropped = (exp_q.size() == DEPTH) && !pop_exec;
    send_frame({8'hC7, s}, 1, pop_exec);
    if (dropped) begin
      if (exp_ovr < 255) exp_ovr++;
    end else begin
      exp_q.push_back(s);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    smp_ready = 1'b1;
    while (exp_q.size() > 0 && n < 64) begin
      checks++;
      if (smp_valid !== 1'b1 || {smp_left, smp_right} !== exp_q[0]) begin
        errors++;
        $display("FAIL drain_head[%0d]: got v=%b %h, want v=1 %h", n, smp_valid,
                 {smp_left, smp_right}, exp_q[0]);
      end
      void'(exp_q.pop_front());
      n++;
      @(posedge clk); #1;
    end
    smp_ready = 1'b0;
    checks++;
    if (smp_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got smp_valid=%b, want 0", smp_valid);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    exp_q.delete();
    exp_err = 0;
    exp_ovr = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({smp_valid, smp_left, smp_right, volume, brightness, kbd_poll, err_cnt, ovr_cnt, kms_reset} !== '0) begin
      errors++;
      $display("FAIL reset_in: outputs not all zero (v=%b l=%h r=%h vol=%h br=%h e=%h o=%h)",
               smp_valid, smp_left, smp_right, volume, brightness, err_cnt, ovr_cnt);
    end
    idle(3);
    rst_n = 1'b1;
    idle(2);
    checks++;
    if ({smp_valid, smp_left, smp_right, volume, brightness, kbd_poll, err_cnt, ovr_cnt, kms_reset} !== '0) begin
      errors++;
      $display("FAIL reset_out: outputs not all zero after release (v=%b vol=%h e=%h o=%h)",
               smp_valid, volume, err_cnt, ovr_cnt);
    end
  endtask

  task automatic test_audio();
    send_audio(32'h1234_ABCD, 1'b0);
    checks++;
    if (smp_valid !== 1'b1 || smp_left !== 16'h1234 || smp_right !== 16'hABCD) begin
      errors++;
      $display("FAIL audio_first: got v=%b l=%h r=%h, want v=1 l=1234 r=abcd",
               smp_valid, smp_left, smp_right);
    end
    idle(GAP);
    send_audio(32'h0F0F_F0F0, 1'b0);
    idle(GAP);
    drain();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < DEPTH + 1; i++) begin
      send_audio({16'h1000 + 16'(i), 16'($urandom)}, 1'b0);
      idle(GAP);
    end
    checks++;
    if (ovr_cnt !== 8'(exp_ovr) || exp_ovr != 1) begin
      errors++;
      $display("FAIL overrun_cnt: got %0d, want 1", ovr_cnt);
    end
    checks++;
    if (smp_valid !== 1'b1 || {smp_left, smp_right} !== exp_q[0]) begin
      errors++;
      $display("FAIL overrun_head: got %h, want %h", {smp_left, smp_right}, exp_q[0]);
    end
  endtask

  task automatic test_push_pop_full();
    send_audio(32'hBEEF_CAFE, 1'b1);
    idle(GAP);
    checks++;
    if (ovr_cnt !== 8'(exp_ovr)) begin
      errors++;
      $display("FAIL full_pushpop_ovr: got %0d, want %0d", ovr_cnt, exp_ovr);
    end
    checks++;
    if (exp_q.size() != DEPTH) begin
      errors++;
      $display("FAIL full_pushpop_model: got %0d entries, want %0d", exp_q.size(), DEPTH);
    end
    drain();
  endtask

  task automatic test_regs();
    int p0;
    send_frame(40'hC4_0000_003F, 1, 1'b0);
    checks++;
    if (volume !== 6'h3F) begin
      errors++;
      $display("FAIL volume: got %h, want 3f", volume);
    end
    idle(GAP);
    send_frame(40'hC5_0000_0015, 1, 1'b0);
    checks++;
    if (brightness !== 6'h15 || volume !== 6'h3F) begin
      errors++;
      $display("FAIL brightness: got br=%h vol=%h, want br=15 vol=3f", brightness, volume);
    end
    idle(GAP);
    p0 = poll_seen;
    send_frame(40'hC6_0000_0000, 1, 1'b0);
    checks++;
    if (kbd_poll !== 1'b1) begin
      errors++;
      $display("FAIL poll_pulse: got %b, want 1", kbd_poll);
    end
    idle(GAP);
    checks++;
    if (poll_seen - p0 != 1) begin
      errors++;
      $display("FAIL poll_count: got %0d pulses, want 1", poll_seen - p0);
    end
    send_frame(40'hC4_FFFF_FFC1, 1, 1'b0);
    checks++;
    if (volume !== 6'h01 || err_cnt !== 8'(exp_err)) begin
      errors++;
      $display("FAIL volume_mask: got vol=%h err=%0d, want vol=01 err=%0d", volume, err_cnt, exp_err);
    end
    idle(GAP);
  endtask

  task automatic test_err_sat();
    send_frame(40'h00_0000_0000, 3, 1'b0);
    exp_err++;
    idle(GAP);
    checks++;
    if (err_cnt !== 8'(exp_err)) begin
      errors++;
      $display("FAIL err_held_valid: got %0d, want %0d", err_cnt, exp_err);
    end
    for (int i = 1; i < 300; i++) begin
      send_frame({8'h00, 32'($urandom)}, 1, 1'b0);
      if (exp_err < 255) exp_err++;
      idle(GAP);
      if (i == 254 || i == 299) begin
        checks++;
        if (err_cnt !== 8'(exp_err)) begin
          errors++;
          $display("FAIL err_sat[%0d]: got %0d, want %0d", i, err_cnt, exp_err);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    send_frame(40'hC4_0000_0033, 1, 1'b0);
    idle(GAP);
    @(posedge clk); #1;
    frame_data  = 40'hC5_0000_002A;
    frame_valid = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (volume !== 6'h00 || err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL async_clear: got vol=%h err=%0d, want 0 0", volume, err_cnt);
    end
    idle(2);
    rst_n = 1'b1;
    idle(GAP);
    checks++;
    if (brightness !== 6'h00 || volume !== 6'h00) begin
      errors++;
      $display("FAIL async_drop_frame: got br=%h vol=%h, want 0 0", brightness, volume);
    end
    exp_q.delete();
    exp_err = 0;
    exp_ovr = 0;
  endtask

  task automatic test_reset_frame();
    int k0;
    apply_reset();
    send_frame(40'hC4_0000_003F, 1, 1'b0);
    idle(GAP);
    send_audio(32'h5555_AAAA, 1'b0);
    idle(GAP);
    k0 = kms_seen;
    send_frame(40'hFF_FFFF_FFFF, 1, 1'b0);
`ifdef NEXTKMS_RESET_FRAME_EN
    checks++;
    if (kms_reset !== 1'b1 || smp_valid !== 1'b0 || volume !== 6'h00 || err_cnt !== 8'h00 || ovr_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_frame: got kms=%b v=%b vol=%h e=%0d o=%0d, want 1 0 0 0 0",
               kms_reset, smp_valid, volume, err_cnt, ovr_cnt);
    end
    exp_q.delete();
    idle(GAP);
    checks++;
    if (kms_seen - k0 != 1) begin
      errors++;
      $display("FAIL reset_frame_pulse: got %0d pulses, want 1", kms_seen - k0);
    end
`else
    exp_err++;
    checks++;
    if (err_cnt !== 8'(exp_err) || volume !== 6'h3F) begin
      errors++;
      $display("FAIL reset_frame_off: got err=%0d vol=%h, want err=%0d vol=3f", err_cnt, volume, exp_err);
    end
    idle(GAP);
    checks++;
    if (kms_seen - k0 != 0) begin
      errors++;
      $display("FAIL reset_frame_off_pulse: got %0d pulses, want 0", kms_seen - k0);
    end
`endif
    drain();
  endtask

  initial begin
    test_reset();
    test_audio();
    test_overrun();
    test_push_pop_full();
    test_regs();
    test_err_sat();
    test_async_reset();
    test_reset_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nextkms_frame_decoder.md
Name: nextkms_frame_decoder

Overview:
- Consumes the 40-bit frames produced by the serial frame receiver of the NeXT KMS link (data[39:0] plus a one-cycle valid strobe).
- Decodes the opcode byte, updates the control registers (volume, brightness) and emits keyboard poll pulses.
- Buffers stereo audio samples in a small FIFO drained by the downstream audio DAC stage via valid/ready.
- Sits directly downstream of the receiver, in the same clk domain.

Parameters:
- FIFO_DEPTH, 8, audio sample FIFO depth in entries; power of 2, minimum 2.
- CNT_W, 8, width of the saturating error and overrun counters.

Ports:
- clk  in  1  system clock; the receiver runs on the same clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_data  in  40  frame from the receiver; bit 39 is the first bit received.
- frame_valid  in  1  receiver valid strobe; may stay high for more than one cycle.
- smp_left  out  16  FIFO head, left sample.
- smp_right  out  16  FIFO head, right sample.
- smp_valid  out  1  FIFO not empty.
- smp_ready  in  1  consumer pops the head when smp_valid and smp_ready are both high.
- volume  out  6  last volume setting.
- brightness  out  6  last brightness setting.
- kbd_poll  out  1  one-cycle pulse per poll frame.
- err_cnt  out  CNT_W  saturating count of unknown opcodes.
- ovr_cnt  out  CNT_W  saturating count of samples dropped because the FIFO was full.
- kms_reset  out  1  one-cycle pulse on a reset frame (optional feature only).

Behaviour:
- Reset: every output is 0, including smp_valid. FIFO is empty and the FSM is in IDLE.
- Edge detect:
  - frame_valid is registered (fv_q).
  - A frame is accepted on frame_valid && !fv_q, i.e. on the rising edge.
  - In that same cycle frame_data is latched into frm_q.
- FSM states: IDLE, EXEC.
  - IDLE to EXEC on an accepted edge.
  - EXEC to IDLE unconditionally, after one cycle.
  - Rising edges seen while in EXEC are still latched and processed in the following EXEC. They cannot be lost: frames are at least 42 clocks apart.
- Opcode = frm_q[39:32]. Actions occur in the EXEC cycle; results are visible one cycle after EXEC, i.e. 2 clocks after the edge.
  - 0xC7 audio: push {frm_q[31:16] as left, frm_q[15:0] as right} into the FIFO. If the FIFO is full and no pop happens in that cycle, drop the sample and increment ovr_cnt.
  - 0xC4 volume: volume <= frm_q[5:0].
  - 0xC5 brightness: brightness <= frm_q[5:0].
  - 0xC6 poll: kbd_poll is high for exactly one cycle.
  - Any other opcode: increment err_cnt; no other effect.
- Counters saturate at all-ones and never wrap. They are cleared only by rst_n, or by a reset frame when the optional feature is enabled.
- FIFO:
  - First-word fall-through: smp_left/smp_right always show the head entry whenever smp_valid is high.
  - Push and pop in the same cycle are both honoured when the FIFO is full, and also when it is not empty.
  - Pop while empty is ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
- Reset asserted mid-operation: immediate asynchronous clear of all state, including a frame latched but not yet executed.

Optional Feature:
- Macro: NEXTKMS_RESET_FRAME_EN.
- Defined: a frame equal to 40'hFF_FFFF_FFFF, processed in EXEC, does the following:
  - pulses kms_reset for one cycle;
  - empties the FIFO;
  - zeroes volume, brightness, err_cnt and ovr_cnt.
  - It does not increment err_cnt.
- Undefined: the kms_reset port is still present and tied to 0; opcode 0xFF is an unknown opcode and increments err_cnt.

Decomposition:
- Package nextkms_pkg holds:
  - the opcode localparams OP_AUDIO=8'hC7, OP_VOL=8'hC4, OP_BRIGHT=8'hC5, OP_POLL=8'hC6;
  - RESET_FRAME=40'hFF_FFFF_FFFF;
  - the FSM state encoding.
- Sub-module nextkms_sample_fifo:
  - parameterised synchronous FWFT FIFO, 32 bits wide;
  - outputs full and empty;
  - instantiated once.

Test Plan:
- Frame 40'hC7_1234_ABCD, smp_ready=0 -> 2 clocks after the edge: smp_valid=1, smp_left=16'h1234, smp_right=16'hABCD.
- 9 audio frames into an 8-deep FIFO, smp_ready=0 -> 8 entries held, ovr_cnt=1; the first entry is still at the head.
- Frames C4_0000_003F, then C5_0000_0015, then C6_0000_0000 -> volume=6'h3F, brightness=6'h15, exactly one kbd_poll pulse.
- 300 frames with opcode 8'h00 -> err_cnt saturates at 8'hFF; frame_valid held high 3 cycles counts only once.
- FIFO full with push and pop in the same EXEC cycle -> no overrun; the entry count stays 8; FIFO order is preserved.
- Reset frame FF_FFFF_FFFF -> with the macro: kms_reset pulse, FIFO empty, registers 0. Without the macro: err_cnt increments and kms_reset stays 0.
